// File: rtl/snake_pkg.sv
// Shared definitions for the snake grid engine: direction codes, FSM states and helpers.
package snake_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [2:0] {
        StInitClr,
        StInitWr,
        StIdle,
        StCalc,
        StCheck,
        StCommitTail,
        StCommitHead,
        StDead
    } snake_state_e;

    // Right/left and up/down differ only in bit 0.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/snake_occ_ram.sv
// Single-bit occupancy bitmap: port A for the engine FSM, port B for pixel lookups.
module snake_occ_ram #(
    parameter int unsigned Depth = 1200,
    parameter int unsigned AddrW = 11
) (
    input  logic             px_clk,
    input  logic             a_we_i,
    input  logic [AddrW-1:0] a_addr_i,
    input  logic             a_wdata_i,
    output logic             a_rdata_o,
    input  logic [AddrW-1:0] b_addr_i,
    output logic             b_rdata_o
);

    logic mem_q [Depth];

    always_ff @(posedge px_clk) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        a_rdata_o <= mem_q[a_addr_i];
    end

    always_ff @(posedge px_clk) begin
        b_rdata_o <= mem_q[b_addr_i];
    end

endmodule

// File: rtl/snake_grid_engine.sv
// Snake body engine: ring buffer of cells plus occupancy bitmap, stepped once per tick.
// Define SNAKE_WRAP_EN to make the grid edges wrap instead of killing the snake.
module snake_grid_engine
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W    = 40,
    parameter int unsigned GRID_H    = 30,
    parameter int unsigned CELL_LOG2 = 4,
    parameter int unsigned MAX_LEN   = 64,
    parameter int unsigned INIT_LEN  = 4,
    parameter int unsigned INIT_X    = 20,
    parameter int unsigned INIT_Y    = 15
) (
    input  logic                         px_clk,
    input  logic                         rstn,
    input  logic                         tick_i,
    input  logic                         dir_valid_i,
    input  logic [1:0]                   dir_i,
    input  logic                         grow_i,
    input  logic [9:0]                   x_px_i,
    input  logic [9:0]                   y_px_i,
    output logic                         pix_on_o,
    output logic                         head_pix_o,
    output logic                         ready_o,
    output logic                         alive_o,
    output logic [$clog2(MAX_LEN+1)-1:0] len_o,
    output logic                         collision_o
);

    localparam int unsigned CW    = $clog2(GRID_W);
    localparam int unsigned RW    = $clog2(GRID_H);
    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned AW    = $clog2(CELLS);
    localparam int unsigned PW    = $clog2(MAX_LEN);
    localparam int unsigned LW    = $clog2(MAX_LEN + 1);

`ifdef SNAKE_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    typedef struct packed {
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } cell_t;

    function automatic logic [AW-1:0] cell_idx(input cell_t c);
        return AW'(32'(c.row) * GRID_W + 32'(c.col));
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + PW'(1);
    endfunction

    snake_state_e  state_q;
    logic [AW-1:0] cnt_q;
    logic [1:0]    cur_dir_q, pend_dir_q;
    logic          pend_dir_vld_q, tick_pend_q, grow_q, step_grow_q;
    cell_t         nh_q;
    logic [PW-1:0] head_ptr_q, tail_ptr_q;
    logic [LW-1:0] len_q;
    logic          ready_q, alive_q, collision_q;
    cell_t         ring_q [MAX_LEN];

    cell_t         head, tail, nh, init_cell;
    logic [1:0]    eff_dir, dir_ref;
    logic          at_edge, nh_out, grow_now, kill, active;
    logic [AW-1:0] a_addr, b_addr;
    logic          a_we, a_wdata, a_rdata, b_rdata;

    assign head      = ring_q[head_ptr_q];
    assign tail      = ring_q[tail_ptr_q];
    assign eff_dir   = pend_dir_vld_q ? pend_dir_q : cur_dir_q;
    assign dir_ref   = (state_q == StCalc) ? eff_dir : cur_dir_q;
    assign init_cell = '{row: RW'(INIT_Y), col: CW'(INIT_X - INIT_LEN + 1 + 32'(cnt_q))};
    assign active    = (state_q != StInitClr) && (state_q != StInitWr) && (state_q != StDead);
    assign grow_now  = (grow_q | grow_i) & (len_q != LW'(MAX_LEN));
    // Entering the tail cell is legal only when the tail is about to vacate it.
    assign kill      = a_rdata & ~((nh_q == tail) & ~grow_now);
    assign nh_out    = at_edge & ~WrapEn;

    always_comb begin
        nh      = head;
        at_edge = 1'b0;
        case (eff_dir)
            DIR_RIGHT: begin
                at_edge = (head.col == CW'(GRID_W - 1));
                nh.col  = at_edge ? '0 : head.col + CW'(1);
            end
            DIR_LEFT: begin
                at_edge = (head.col == '0);
                nh.col  = at_edge ? CW'(GRID_W - 1) : head.col - CW'(1);
            end
            DIR_UP: begin
                at_edge = (head.row == '0);
                nh.row  = at_edge ? RW'(GRID_H - 1) : head.row - RW'(1);
            end
            default: begin
                at_edge = (head.row == RW'(GRID_H - 1));
                nh.row  = at_edge ? '0 : head.row + RW'(1);
            end
        endcase
    end

    always_comb begin
        a_addr  = cell_idx(nh_q);
        a_we    = 1'b0;
        a_wdata = 1'b0;
        case (state_q)
            StInitClr: begin
                a_addr = cnt_q;
                a_we   = 1'b1;
            end
            StInitWr: begin
                a_addr  = cell_idx(init_cell);
                a_we    = 1'b1;
                a_wdata = 1'b1;
            end
            StCalc: a_addr = cell_idx(nh);
            StCommitTail: begin
                a_addr = cell_idx(tail);
                a_we   = ~step_grow_q;
            end
            StCommitHead: begin
                a_we    = 1'b1;
                a_wdata = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge px_clk) begin
        if (!rstn) begin
            state_q        <= StInitClr;
            cnt_q          <= '0;
            cur_dir_q      <= DIR_RIGHT;
            pend_dir_q     <= DIR_RIGHT;
            pend_dir_vld_q <= 1'b0;
            tick_pend_q    <= 1'b0;
            grow_q         <= 1'b0;
            step_grow_q    <= 1'b0;
            nh_q           <= '0;
            head_ptr_q     <= '0;
            tail_ptr_q     <= '0;
            len_q          <= '0;
            ready_q        <= 1'b0;
            alive_q        <= 1'b0;
            collision_q    <= 1'b0;
        end else begin
            collision_q <= 1'b0;
            if (active) begin
                if (grow_i) grow_q <= 1'b1;
                if (tick_i && state_q != StIdle) tick_pend_q <= 1'b1;
                if (dir_valid_i && dir_i != opposite_dir(dir_ref)) begin
                    pend_dir_q     <= dir_i;
                    pend_dir_vld_q <= 1'b1;
                end else if (state_q == StCalc) begin
                    pend_dir_vld_q <= 1'b0;
                end
            end
            case (state_q)
                StInitClr: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == AW'(CELLS - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StInitWr;
                    end
                end
                StInitWr: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == AW'(INIT_LEN - 1)) begin
                        state_q    <= StIdle;
                        ready_q    <= 1'b1;
                        alive_q    <= 1'b1;
                        len_q      <= LW'(INIT_LEN);
                        head_ptr_q <= PW'(INIT_LEN - 1);
                        tail_ptr_q <= '0;
                    end
                end
                StIdle: begin
                    if (tick_i || tick_pend_q) begin
                        tick_pend_q <= 1'b0;
                        state_q     <= StCalc;
                    end
                end
                StCalc: begin
                    cur_dir_q <= eff_dir;
                    nh_q      <= nh;
                    if (nh_out) begin
                        state_q     <= StDead;
                        alive_q     <= 1'b0;
                        collision_q <= 1'b1;
                    end else begin
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    step_grow_q <= grow_now;
                    if (kill) begin
                        state_q     <= StDead;
                        alive_q     <= 1'b0;
                        collision_q <= 1'b1;
                    end else begin
                        state_q <= StCommitTail;
                    end
                end
                StCommitTail: begin
                    // Any pending grow is consumed here, even when len is saturated.
                    grow_q  <= grow_i;
                    state_q <= StCommitHead;
                    if (!step_grow_q) tail_ptr_q <= ptr_inc(tail_ptr_q);
                end
                StCommitHead: begin
                    head_ptr_q <= ptr_inc(head_ptr_q);
                    if (step_grow_q) len_q <= len_q + LW'(1);
                    state_q <= StIdle;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge px_clk) begin
        if (state_q == StInitWr) begin
            ring_q[PW'(cnt_q)] <= init_cell;
        end else if (state_q == StCommitHead) begin
            ring_q[ptr_inc(head_ptr_q)] <= nh_q;
        end
    end

    logic [9:0] q_col, q_row;
    logic       q_in, pix_ok_q, head_pix_q;

    assign q_col  = x_px_i >> CELL_LOG2;
    assign q_row  = y_px_i >> CELL_LOG2;
    assign q_in   = (32'(q_col) < GRID_W) && (32'(q_row) < GRID_H);
    assign b_addr = q_in ? AW'(32'(q_row) * GRID_W + 32'(q_col)) : '0;

    always_ff @(posedge px_clk) begin
        if (!rstn) begin
            pix_ok_q   <= 1'b0;
            head_pix_q <= 1'b0;
        end else begin
            pix_ok_q   <= q_in & ready_q;
            head_pix_q <= q_in & ready_q & (q_col == 10'(head.col)) & (q_row == 10'(head.row));
        end
    end

    snake_occ_ram #(
        .Depth (CELLS),
        .AddrW (AW)
    ) u_occ_ram (
        .px_clk    (px_clk),
        .a_we_i    (a_we),
        .a_addr_i  (a_addr),
        .a_wdata_i (a_wdata),
        .a_rdata_o (a_rdata),
        .b_addr_i  (b_addr),
        .b_rdata_o (b_rdata)
    );

    assign pix_on_o    = pix_ok_q & b_rdata;
    assign head_pix_o  = head_pix_q;
    assign ready_o     = ready_q;
    assign alive_o     = alive_q;
    assign len_o       = len_q;
    assign collision_o = collision_q;

endmodule

// File: tb/tb_snake_grid_engine.sv
// Bench for snake_grid_engine: directed scenarios plus random steps against a queue-based model.
module tb_snake_grid_engine;
    import snake_pkg::*;

    localparam int GW = 40;
    localparam int GH = 30;
    localparam int ML = 64;

    logic       px_clk = 1'b0;
    logic       rstn = 1'b0, tick = 1'b0, dir_valid = 1'b0, grow = 1'b0;
    logic [1:0] dir = 2'b00;
    logic [9:0] x_px = '0, y_px = '0;
    logic       pix_on, head_pix, ready, alive, collision;
    logic [6:0] len;

    snake_grid_engine dut (
        .px_clk      (px_clk),
        .rstn        (rstn),
        .tick_i      (tick),
        .dir_valid_i (dir_valid),
        .dir_i       (dir),
        .grow_i      (grow),
        .x_px_i      (x_px),
        .y_px_i      (y_px),
        .pix_on_o    (pix_on),
        .head_pix_o  (head_pix),
        .ready_o     (ready),
        .alive_o     (alive),
        .len_o       (len),
        .collision_o (collision)
    );

    always #5 px_clk = ~px_clk;

    int vectors = 0, miscompares = 0;

    // Model: body[0] is the tail, body[$] the head.
    typedef struct {int c; int r;} xy_t;
    xy_t body[$];
    int  mdir, mpend, mcoll;
    bit  mgrow, malive;
    int  dc[4]  = '{1, -1, 0, 0};
    int  dr[4]  = '{0, 0, -1, 1};
    int  opp[4] = '{1, 0, 3, 2};

    function automatic bit model_occ(input int c, input int r);
        foreach (body[i]) if (body[i].c == c && body[i].r == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        body.delete();
        for (int k = 3; k >= 0; k--) body.push_back('{20 - k, 15});
        mdir = 0; mpend = -1; mgrow = 0; malive = 1;
    endfunction

    function automatic void model_dir(input int d);
        if (malive && d != opp[mdir]) mpend = d;
    endfunction

    function automatic void model_step();
        xy_t h, n;
        bit  grows;
        if (!malive) return;
        if (mpend >= 0) mdir = mpend;
        mpend = -1;
        h = body[$];
        n.c = h.c + dc[mdir];
        n.r = h.r + dr[mdir];
`ifdef SNAKE_WRAP_EN
        n.c = (n.c + GW) % GW;
        n.r = (n.r + GH) % GH;
`else
        if (n.c < 0 || n.c >= GW || n.r < 0 || n.r >= GH) begin
            malive = 0; mcoll++; return;
        end
`endif
        grows = mgrow && body.size() < ML;
        if (model_occ(n.c, n.r) && !(!grows && n.c == body[0].c && n.r == body[0].r)) begin
            malive = 0; mcoll++; return;
        end
        mgrow = 0;
        if (!grows) void'(body.pop_front());
        body.push_back(n);
    endfunction

    task automatic clk1();
        @(posedge px_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic query(input int c, input int r, output logic p, output logic h);
        x_px = 10'(c * 16 + $urandom_range(0, 15));
        y_px = 10'(r * 16 + $urandom_range(0, 15));
        clk1();
        p = pix_on;
        h = head_pix;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pix_on"}, pix_on, 0);
        check({tag, "_head_pix"}, head_pix, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_alive"}, alive, 0);
        check({tag, "_len"}, len, 0);
        check({tag, "_collision"}, collision, 0);
    endtask

    // Ticks and a direction request during INIT must be dropped.
    task automatic reset_dut(input bit chk);
        int n;
        rstn = 1'b0; tick = 1'b0; dir_valid = 1'b0; grow = 1'b0;
        clk1(); clk1();
        if (chk) check_reset_vals("rst");
        rstn = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 2000) begin
            tick = (n == 100); dir_valid = (n == 100); dir = DIR_UP;
            clk1();
            n++;
        end
        tick = 1'b0; dir_valid = 1'b0;
        check("init_cycles", n, 1204);
        model_reset();
    endtask

    task automatic scan(input string tag);
        int bad = 0;
        logic p, h;
        for (int r = 0; r < GH; r++) begin
            for (int c = 0; c < GW; c++) begin
                query(c, r, p, h);
                if (p !== model_occ(c, r) || h !== (c == body[$].c && r == body[$].r)) bad++;
            end
        end
        check(tag, bad, 0);
    endtask

    task automatic do_step(input int nreq, input int d0, input int d1, input bit g,
                           input bit extra);
        int   ncol, c0, rc, rr;
        xy_t  t0;
        logic p, h;
        c0 = mcoll;
        t0 = body[0];
        for (int i = 0; i < nreq; i++) begin
            dir_valid = 1'b1;
            dir = 2'((i == 0) ? d0 : d1);
            model_dir((i == 0) ? d0 : d1);
            clk1();
        end
        dir_valid = 1'b0;
        tick = 1'b1; grow = g;
        if (g) mgrow = 1;
        clk1();
        tick = 1'b0; grow = 1'b0;
        model_step();
        ncol = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick = extra && (cyc == 1 || cyc == 2);
            clk1();
            if (collision === 1'b1) ncol++;
        end
        tick = 1'b0;
        if (extra) model_step();
        check("alive", alive, malive);
        check("len", len, body.size());
        check("collision_pulses", ncol, mcoll - c0);
        query(body[$].c, body[$].r, p, h);
        check("head_pix", h, 1);
        check("head_on", p, 1);
        query(t0.c, t0.r, p, h);
        check("old_tail", p, model_occ(t0.c, t0.r));
        rc = $urandom_range(0, GW - 1);
        rr = $urandom_range(0, GH - 1);
        query(rc, rr, p, h);
        check("rand_cell", p, model_occ(rc, rr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic p, h;
        mcoll = 0;

        // Reset, init, boundary pixel queries, then up / left / down tail chase at len 4.
        reset_dut(1'b1);
        check("ready", ready, 1);
        check("alive_init", alive, 1);
        check("len_init", len, 4);
        scan("scan_init");
        query(57, 14, p, h);
        check("alias_col_pix", p, 0);
        query(60, 14, p, h);
        check("alias_head_pix", p, 0);
        check("alias_head_hp", h, 0);
        query(0, 30, p, h);
        check("row_out_pix", p, 0);
        do_step(2, DIR_DOWN, DIR_UP, 1'b0, 1'b0);
        query(20, 14, p, h);
        check("up_head", h, 1);
        query(17, 15, p, h);
        check("up_tail_off", p, 0);
        check("up_len", len, 4);
        do_step(1, DIR_LEFT, 0, 1'b0, 1'b0);
        do_step(1, DIR_DOWN, 0, 1'b0, 1'b0);
        check("chase_alive", alive, 1);
        query(19, 15, p, h);
        check("chase_head", h, 1);

        // Reverse request ignored, then growth.
        reset_dut(1'b0);
        do_step(1, DIR_LEFT, 0, 1'b0, 1'b0);
        query(21, 15, p, h);
        check("rev_head", h, 1);

        // Same turns at len 5 must collide.
        reset_dut(1'b0);
        do_step(1, DIR_UP, 0, 1'b1, 1'b0);
        check("grow_len", len, 5);
        query(17, 15, p, h);
        check("grow_tail_on", p, 1);
        do_step(1, DIR_LEFT, 0, 1'b0, 1'b0);
        do_step(1, DIR_DOWN, 0, 1'b0, 1'b0);
        check("self_dead", alive, 0);
        do_step(1, DIR_RIGHT, 0, 1'b1, 1'b1);
        check("dead_len", len, 5);

        // Twenty steps right.
        reset_dut(1'b0);
        for (int i = 0; i < 19; i++) do_step(0, 0, 0, 1'b0, 1'b0);
        query(39, 15, p, h);
        check("edge_head", h, 1);
        do_step(0, 0, 0, 1'b0, 1'b0);
`ifdef SNAKE_WRAP_EN
        query(0, 15, p, h);
        check("wrap_head", h, 1);
        check("wrap_alive", alive, 1);
`else
        check("wall_dead", alive, 0);
`endif

        // Grow every step along an L path until len saturates.
        reset_dut(1'b0);
        for (int i = 0; i < 19; i++) do_step(0, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) do_step(1, DIR_DOWN, 0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) do_step(1, DIR_LEFT, 0, 1'b1, 1'b0);
        check("len_sat", len, ML);
        check("sat_alive", alive, 1);
        scan("scan_sat");

        // Random steps; restart whenever the snake dies.
        reset_dut(1'b0);
        for (int i = 0; i < 100; i++) begin
            if (!malive) reset_dut(1'b0);
            do_step($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end

        // Reset asserted while the engine is in COMMIT_TAIL.
        if (!malive) reset_dut(1'b0);
        tick = 1'b1;
        clk1();
        tick = 1'b0;
        clk1();
        clk1();
        rstn = 1'b0;
        clk1();
        check_reset_vals("mid");
        reset_dut(1'b0);
        check("rebuild_len", len, 4);
        scan("scan_rebuild");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
